// File: rtl/mi_arbiter.sv
// rtl/mi_arbiter.sv - two-port memory-interface arbiter with a port-1 starvation bound
//
// Ports:
//   clk_1x, rst                      clock; asynchronous active-high reset
//   p0_addr/p0_len/p0_valid/p0_ready video DMA read command (len = words-1)
//   p0_rstb/p0_rlast                 port-0 read strobe and qualified last word
//   p1_addr/p1_len/p1_rw/p1_valid/p1_ready
//                                    test-engine command (rw: 1 read, 0 write)
//   p1_wdata, p1_wack/p1_wlast       port-1 write data and write acks
//   p1_rstb/p1_rlast                 port-1 read strobe and qualified last word
//   rdata                            controller read data, shared by both ports
//   m_addr/m_len/m_rw/m_valid/m_ready
//                                    command channel to the memory controller
//   m_wdata, m_wack/m_wlast          write data and acks from the controller
//   m_rdata, m_rstb/m_rlast          read data and strobes from the controller
//   owner                            current grant (0 video, 1 test engine)

module mi_arbiter #(
    parameter int MAX_STARVE = 8
) (
    input  logic        clk_1x,
    input  logic        rst,

    input  logic [31:0] p0_addr,
    input  logic [6:0]  p0_len,
    input  logic        p0_valid,
    output logic        p0_ready,
    output logic        p0_rstb,
    output logic        p0_rlast,

    input  logic [31:0] p1_addr,
    input  logic [6:0]  p1_len,
    input  logic        p1_rw,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic [31:0] p1_wdata,
    output logic        p1_wack,
    output logic        p1_wlast,
    output logic        p1_rstb,
    output logic        p1_rlast,

    output logic [31:0] rdata,

    output logic [31:0] m_addr,
    output logic [6:0]  m_len,
    output logic        m_rw,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_wdata,
    input  logic        m_wack,
    input  logic        m_wlast,
    input  logic        m_rstb,
    input  logic        m_rlast,
    input  logic [31:0] m_rdata,

    output logic        owner
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [3:0]  starve_q, starve_d;
    logic        rd_q, rd_d;          // latched direction of the transfer in flight
    logic        own_valid;
    logic        starve_ok;

    always_ff @(posedge clk_1x or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            starve_q <= 4'd0;
            rd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            rd_q     <= rd_d;
        end
    end

    assign own_valid = owner_q ? p1_valid : p0_valid;
    // Port 0 wins ties until it has taken MAX_STARVE grants in a row past a waiting port 1.
    assign starve_ok = (starve_q < STARVE_LIMIT);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        rd_d     = rd_q;
        case (state_q)
            ST_IDLE: begin
                if (p0_valid && (starve_ok || !p1_valid)) begin
                    owner_d = 1'b0;
                    state_d = ST_CMD;
                    // Only grants that make port 1 wait count toward starvation.
                    if (p1_valid && starve_ok) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (p1_valid) begin
                    owner_d  = 1'b1;
                    starve_d = 4'd0;
                    state_d  = ST_CMD;
                end
            end
            ST_CMD: begin
                if (!own_valid) begin
                    // Owner withdrew its request; abandon without issuing.
                    state_d = ST_IDLE;
                end else if (m_ready) begin
                    state_d = ST_DATA;
                    rd_d    = owner_q ? p1_rw : 1'b1;
                end
            end
            ST_DATA: begin
                if (rd_q ? (m_rstb && m_rlast) : (m_wack && m_wlast)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and strobe routing; everything is held low outside the phase
    // it belongs to so stray controller strobes never reach a port.
    always_comb begin
        m_valid  = 1'b0;
        p0_ready = 1'b0;
        p1_ready = 1'b0;
        p0_rstb  = 1'b0;
        p0_rlast = 1'b0;
        p1_rstb  = 1'b0;
        p1_rlast = 1'b0;
        p1_wack  = 1'b0;
        p1_wlast = 1'b0;
        if (state_q == ST_CMD) begin
            m_valid  = own_valid;
            p0_ready = m_ready && !owner_q;
            p1_ready = m_ready && owner_q;
        end
        if (state_q == ST_DATA) begin
            if (rd_q) begin
                if (owner_q) begin
                    p1_rstb  = m_rstb;
                    p1_rlast = m_rstb && m_rlast;
                end else begin
                    p0_rstb  = m_rstb;
                    p0_rlast = m_rstb && m_rlast;
                end
            end else if (owner_q) begin
                p1_wack  = m_wack;
                p1_wlast = m_wack && m_wlast;
            end
        end
    end

    assign m_addr  = owner_q ? p1_addr : p0_addr;
    assign m_len   = owner_q ? p1_len  : p0_len;
    assign m_rw    = owner_q ? p1_rw   : 1'b1;
    assign m_wdata = p1_wdata;
    assign rdata   = m_rdata;
    assign owner   = owner_q;

endmodule

// File: tb/tb_mi_arbiter.sv
// tb/tb_mi_arbiter.sv - self-checking bench for mi_arbiter
module tb_mi_arbiter;
    localparam int MAX = 8;

    logic        clk_1x = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] p0_addr = '0, p1_addr = '0, p1_wdata = '0, m_rdata = '0;
    logic [6:0]  p0_len = '0, p1_len = '0;
    logic        p0_valid = 1'b0, p1_valid = 1'b0, p1_rw = 1'b0;
    logic        m_ready = 1'b0, m_wack = 1'b0, m_wlast = 1'b0, m_rstb = 1'b0, m_rlast = 1'b0;
    logic        p0_ready, p0_rstb, p0_rlast, p1_ready, p1_wack, p1_wlast, p1_rstb, p1_rlast;
    logic [31:0] rdata, m_addr, m_wdata;
    logic [6:0]  m_len;
    logic        m_rw, m_valid, owner;

    mi_arbiter #(.MAX_STARVE(MAX)) dut (
        .clk_1x(clk_1x), .rst(rst),
        .p0_addr(p0_addr), .p0_len(p0_len), .p0_valid(p0_valid), .p0_ready(p0_ready),
        .p0_rstb(p0_rstb), .p0_rlast(p0_rlast),
        .p1_addr(p1_addr), .p1_len(p1_len), .p1_rw(p1_rw), .p1_valid(p1_valid),
        .p1_ready(p1_ready), .p1_wdata(p1_wdata), .p1_wack(p1_wack), .p1_wlast(p1_wlast),
        .p1_rstb(p1_rstb), .p1_rlast(p1_rlast), .rdata(rdata),
        .m_addr(m_addr), .m_len(m_len), .m_rw(m_rw), .m_valid(m_valid), .m_ready(m_ready),
        .m_wdata(m_wdata), .m_wack(m_wack), .m_wlast(m_wlast), .m_rstb(m_rstb),
        .m_rlast(m_rlast), .m_rdata(m_rdata), .owner(owner)
    );

    always #5 clk_1x = ~clk_1x;

    int n_checks = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // stimulus knobs and master/controller state
    bit p0_pend = 0, p1_pend = 0;
    int gen_pct = 0, drop_pct = 0, ready_pct = 0, strobe_pct = 0, noise_pct = 0, len_max = 3;
    int ctl_left = 0;
    bit ctl_rd = 0;

    // reference model: phase 0 idle, 1 command, 2 data
    int mp = 0;
    bit mo = 0, mr = 0;
    int ms = 0;

    // observations
    int cnt_p0_rstb, cnt_p0_rlast, cnt_p1_rstb, cnt_p1_rlast, cnt_p1_wack, cnt_p1_wlast, cnt_hs;
    bit hs_rw;
    bit grants[$];

    function automatic bit roll(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic clr_cnt();
        cnt_p0_rstb = 0; cnt_p0_rlast = 0; cnt_p1_rstb = 0; cnt_p1_rlast = 0;
        cnt_p1_wack = 0; cnt_p1_wlast = 0; cnt_hs = 0;
    endtask

    task automatic drive();
        bit s;
        if (gen_pct > 0) begin
            if (!p0_pend && roll(gen_pct)) begin
                p0_pend = 1;
                p0_addr = {4'h0, 28'($urandom)};
                p0_len  = 7'($urandom_range(len_max));
            end
            if (!p1_pend && roll(gen_pct)) begin
                p1_pend = 1;
                p1_addr = {4'h1, 28'($urandom)};
                p1_len  = 7'($urandom_range(len_max));
                p1_rw   = 1'($urandom);
            end
            if (p0_pend && roll(drop_pct)) p0_pend = 0;
            if (p1_pend && roll(drop_pct)) p1_pend = 0;
        end
        p0_valid = p0_pend;
        p1_valid = p1_pend;
        p1_wdata = $urandom;
        m_rdata  = $urandom;
        m_ready  = roll(ready_pct);
        if (ctl_left > 0) begin
            s = roll(strobe_pct);
            if (ctl_rd) begin
                m_rstb = s; m_rlast = s && (ctl_left == 1);
                m_wack = roll(noise_pct); m_wlast = 1'($urandom);
            end else begin
                m_wack = s; m_wlast = s && (ctl_left == 1);
                m_rstb = roll(noise_pct); m_rlast = 1'($urandom);
            end
        end else begin
            m_rstb = roll(noise_pct); m_rlast = 1'($urandom);
            m_wack = roll(noise_pct); m_wlast = 1'($urandom);
        end
    endtask

    task automatic tick(input bit r);
        bit v, done;
        logic [3:0] e_ctl;
        logic [5:0] e_str;
        @(posedge clk_1x);
        #1;
        rst = r;
        drive();
        @(negedge clk_1x);
        if (rst) begin mp = 0; mo = 0; mr = 0; ms = 0; end
        v     = (mp == 1) && (mo ? p1_valid : p0_valid);
        e_ctl = {v, (mp == 1) && !mo && m_ready, (mp == 1) && mo && m_ready, mo};
        e_str = {(mp == 2) && mr && !mo && m_rstb, (mp == 2) && mr && !mo && m_rstb && m_rlast,
                 (mp == 2) && mr && mo && m_rstb,  (mp == 2) && mr && mo && m_rstb && m_rlast,
                 (mp == 2) && !mr && mo && m_wack, (mp == 2) && !mr && mo && m_wack && m_wlast};
        check_eq("ctl", {m_valid, p0_ready, p1_ready, owner}, e_ctl);
        check_eq("strobes", {p0_rstb, p0_rlast, p1_rstb, p1_rlast, p1_wack, p1_wlast}, e_str);
        check_eq("passthru", {rdata, m_wdata}, {m_rdata, p1_wdata});
        if (mp == 1)
            check_eq("cmd", {m_addr, m_len, m_rw},
                     {mo ? p1_addr : p0_addr, mo ? p1_len : p0_len, mo ? p1_rw : 1'b1});

        cnt_p0_rstb += p0_rstb; cnt_p0_rlast += p0_rlast;
        cnt_p1_rstb += p1_rstb; cnt_p1_rlast += p1_rlast;
        cnt_p1_wack += p1_wack; cnt_p1_wlast += p1_wlast;
        if (m_valid && m_ready) begin
            cnt_hs++;
            hs_rw = m_rw;
            grants.push_back(owner);
        end

        if (ctl_left > 0 && (ctl_rd ? m_rstb : m_wack)) ctl_left--;
        if (!rst) begin
            if (mp == 0) begin
                if (p0_valid && (ms < MAX || !p1_valid)) begin
                    mo = 0; mp = 1;
                    if (p1_valid) ms = (ms + 1 > MAX) ? MAX : ms + 1;
                end else if (p1_valid) begin
                    mo = 1; mp = 1; ms = 0;
                end
            end else if (mp == 1) begin
                if (!v) mp = 0;
                else if (m_ready) begin
                    mp = 2;
                    mr = mo ? p1_rw : 1'b1;
                    ctl_left = (mo ? int'(p1_len) : int'(p0_len)) + 1;
                    ctl_rd = mr;
                    if (mo) p1_pend = 0; else p0_pend = 0;
                end
            end else begin
                done = mr ? (m_rstb && m_rlast) : (m_wack && m_wlast);
                if (done) mp = 0;
            end
        end
    endtask

    initial begin
        clr_cnt();

        // reset with activity on every input
        p0_pend = 1; ready_pct = 50; noise_pct = 50;
        repeat (3) tick(1);
        check_eq("reset_outs", {m_valid, p0_ready, p1_ready, p0_rstb, p0_rlast, p1_rstb,
                                p1_rlast, p1_wack, p1_wlast, owner}, 0);
        p0_pend = 0; noise_pct = 0;
        repeat (2) tick(0);

        // port 0 read of 8 words
        clr_cnt(); ready_pct = 100; strobe_pct = 100;
        p0_addr = 32'h0000_1000; p0_len = 7'd7; p0_pend = 1;
        tick(0);
        check_eq("lat_n", m_valid, 0);
        tick(0);
        check_eq("lat_n1", {m_valid, cnt_hs[3:0]}, {1'b1, 4'd1});
        repeat (12) tick(0);
        check_eq("p0_rstb_cnt", cnt_p0_rstb, 8);
        check_eq("p0_rlast_cnt", cnt_p0_rlast, 1);
        check_eq("p0_p1_rstb", cnt_p1_rstb, 0);

        // port 1 write of 4 words
        clr_cnt();
        p1_addr = 32'h1000_0040; p1_len = 7'd3; p1_rw = 0; p1_pend = 1;
        repeat (10) tick(0);
        check_eq("wr_rw", {cnt_hs[3:0], hs_rw}, {4'd1, 1'b0});
        check_eq("wack_cnt", cnt_p1_wack, 4);
        check_eq("wlast_cnt", cnt_p1_wlast, 1);
        check_eq("wr_p0_quiet", cnt_p0_rstb + cnt_p0_rlast, 0);

        // stray controller strobes while idle
        clr_cnt(); noise_pct = 100;
        repeat (4) tick(0);
        check_eq("stray_idle", cnt_p0_rstb + cnt_p1_rstb + cnt_p1_wack, 0);
        noise_pct = 0;

        // both ports requesting continuously
        grants.delete();
        gen_pct = 100; drop_pct = 0; len_max = 1;
        for (int k = 0; k < 600 && grants.size() < 27; k++) tick(0);
        check_eq("grant_cnt", grants.size() >= 27, 1);
        for (int i = 0; i < 27 && i < grants.size(); i++)
            check_eq($sformatf("grant%0d", i), grants[i], (i % 9 == 8) ? 1 : 0);
        gen_pct = 0; p0_pend = 0; p1_pend = 0;
        tick(1);
        tick(0);

        // reset in the middle of a read burst
        clr_cnt(); len_max = 7;
        p0_addr = 32'h0000_2000; p0_len = 7'd7; p0_pend = 1;
        for (int k = 0; k < 20 && cnt_p0_rstb < 3; k++) tick(0);
        check_eq("rst_mid_cnt", cnt_p0_rstb, 3);
        tick(1);
        check_eq("rst_mid_outs", {m_valid, p0_ready, p1_ready, p0_rstb, p0_rlast, p1_rstb,
                                  p1_rlast, owner}, 0);
        clr_cnt();
        repeat (8) tick(0);
        check_eq("after_rst", cnt_p0_rstb + cnt_p0_rlast + cnt_p1_rstb + cnt_hs, 0);

        // owner withdraws in the command phase
        clr_cnt(); ready_pct = 0; p0_pend = 1;
        tick(0);
        tick(0);
        check_eq("drop_cmd", m_valid, 1);
        p0_pend = 0;
        tick(0);
        check_eq("drop_mvalid", m_valid, 0);
        tick(0);
        check_eq("drop_no_hs", cnt_hs, 0);

        // randomized traffic with occasional resets
        gen_pct = 30; drop_pct = 2; ready_pct = 60; strobe_pct = 70; noise_pct = 20; len_max = 7;
        for (int k = 0; k < 4000; k++) tick($urandom_range(399) == 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
